uart_frame_bit_counter: RTL and testbench
=========================================

// Module: uart_frame_bit_counter
// PURPOSE
//   Parametrised successor to the fixed 11-bit UART frame counter. Counts bit-time ticks (btu)
//   while doit is high. Frame length is run-time configurable: start bit, 5..MAX_DATA_BITS data
//   bits, optional parity, 1 or 2 stop bits. Reports the current frame phase and data-bit index.
//   Sits between the baud-rate tick generator and the TX/RX shift-register FSMs.
// PARAMETERS
//   MAX_DATA_BITS  8   largest legal data_bits value (range 5..15)
//   CNT_W          4   count width; must hold 1+MAX_DATA_BITS+1+2
// PORTS
//   clk         in   1      system clock; all state updates on rising edge
//   reset_n     in   1      asynchronous, active-low reset
//   doit        in   1      frame active; low forces IDLE
//   btu         in   1      one-cycle bit-time tick from baud generator
//   data_bits   in   4      data bits per frame; sampled at frame start only
//   parity_en   in   1      1 = frame carries a parity bit; sampled at frame start
//   stop2       in   1      1 = two stop bits, 0 = one; sampled at frame start
//   count       out  CNT_W  bit-times elapsed in current frame
//   bit_idx     out  4      data-bit index (0 = LSB) while phase==DATA, else 0
//   phase       out  3      0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 DONE
//   done        out  1      level; high while state==DONE
//   done_pulse  out  1      single-cycle pulse on entry to DONE
//   overrun     out  1      sticky btu-after-done flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (reset_n=0, async): state=IDLE, count=0, bit_idx=0, phase=0, done=0, done_pulse=0, overrun=0.
//   - Latched config: D = clamp(data_bits, 5, MAX_DATA_BITS); L = 1 + D + parity_en + (stop2 ? 2 : 1).
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE:
//       doit=1 -> RUN next edge; latch D, parity, stop2; count=0.
//       A btu coincident with the doit rise is ignored.
//   - RUN:
//       btu=1 -> count<=count+1.
//       If count+1==L -> DONE, with done_pulse=1 for that one cycle.
//       btu=0 -> hold.
//   - DONE:
//       count saturates at L; further btu does not change count.
//       done=1 until doit falls.
//   - doit=0 in any state -> IDLE next edge: count=0, done=0, overrun cleared.
//     Mid-frame abort has no done_pulse.
//   - Phase decode from count (registered with count, zero added latency):
//       count=0 -> START; 1..D -> DATA with bit_idx=count-1; D+1 -> PARITY if enabled;
//       remaining counts < L -> STOP; count=L -> DONE.
//       IDLE state -> phase 0.
//   - Changes on data_bits/parity_en/stop2 during RUN/DONE have no effect until the next IDLE->RUN.
//   - Arithmetic is unsigned CNT_W. L never exceeds 2^CNT_W-1, so there is no wrap-around.
//   - Sanity check on MAX_DATA_BITS/CNT_W mismatch: L > 2^CNT_W-1 triggers $error in a generate block.
// CONFIGURATION
//   UART_BITCNT_OVERRUN_EN defined:
//     - btu in DONE with doit=1 sets overrun=1.
//     - overrun is sticky until doit=0 or reset.
//   UART_BITCNT_OVERRUN_EN undefined:
//     - overrun tied to 0; no flop inferred.
//     - btu in DONE silently ignored.
// TESTING
//   1 8E1 (data_bits=8, parity_en=1, stop2=0), doit=1, 11 btu ->
//     phases START, DATA x8 (bit_idx 0..7), PARITY, STOP;
//     done=1 and done_pulse=1 for one cycle after the 11th btu.
//   2 7N2 (data_bits=7, parity_en=0, stop2=1) ->
//     done after the 10th btu; phase STOP at count 8 and 9.
//   3 Clamp: data_bits=3 -> behaves as D=5, L=7; data_bits=12 -> D=8.
//   4 Abort: drop doit at count=4 ->
//     next edge count=0, phase=IDLE, no done_pulse; reassert restarts from count 0.
//   5 Config change mid-frame: switch 8E1->5N1 at count=3 -> frame still ends at count=11.
//   6 Post-done btu (x2) ->
//     count stays 11, done stays 1; overrun=1 only with UART_BITCNT_OVERRUN_EN.
//     Pulse reset_n mid-frame -> all outputs 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/uart_frame_bit_counter.sv
// UART frame bit-time counter: start, 5..MAX_DATA_BITS data, optional parity, 1/2 stop bits.
// Optional sticky btu-after-done flag enabled by the UART_BITCNT_OVERRUN_EN macro.
`timescale 1ns/1ps

module uart_frame_bit_counter #(
    parameter int MAX_DATA_BITS = 8,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             doit,
    input  logic             btu,
    input  logic [3:0]       data_bits,
    input  logic             parity_en,
    input  logic             stop2,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       bit_idx,
    output logic [2:0]       phase,
    output logic             done,
    output logic             done_pulse,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_STOP   = 3'd4,
        PH_DONE   = 3'd5
    } phase_t;

    localparam int         MAX_LEN = MAX_DATA_BITS + 4;
    localparam logic [3:0] MAX_D   = 4'(MAX_DATA_BITS);
    localparam logic [3:0] MIN_D   = 4'd5;

    generate
        if (MAX_LEN > (2 ** CNT_W) - 1) begin : g_len_chk
            $error("uart_frame_bit_counter: CNT_W too narrow for MAX_DATA_BITS");
        end
        if (MAX_DATA_BITS < 5 || MAX_DATA_BITS > 15) begin : g_maxd_chk
            $error("uart_frame_bit_counter: MAX_DATA_BITS must be in 5..15");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       dbits_q, dbits_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_pulse_q, done_pulse_d;

    logic [3:0]       dbits_clamp;
    logic [CNT_W-1:0] len_start;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        dbits_clamp = data_bits;
        if (data_bits < MIN_D) begin
            dbits_clamp = MIN_D;
        end else if (data_bits > MAX_D) begin
            dbits_clamp = MAX_D;
        end
    end

    // Frame length in bit-times: start + data + parity + stop(s).
    assign len_start = CNT_W'(1) + CNT_W'(dbits_clamp) + CNT_W'(parity_en)
                     + (stop2 ? CNT_W'(2) : CNT_W'(1));
    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        dbits_d      = dbits_q;
        par_d        = par_q;
        len_d        = len_q;
        done_pulse_d = 1'b0;
        if (!doit) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A btu arriving with the doit rise is deliberately dropped.
                    state_d = S_RUN;
                    count_d = '0;
                    dbits_d = dbits_clamp;
                    par_d   = parity_en;
                    len_d   = len_start;
                end
                S_RUN: begin
                    if (btu) begin
                        count_d = count_inc;
                        if (count_inc == len_q) begin
                            state_d      = S_DONE;
                            done_pulse_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            dbits_q      <= MIN_D;
            par_q        <= 1'b0;
            len_q        <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            dbits_q      <= dbits_d;
            par_q        <= par_d;
            len_q        <= len_d;
            done_pulse_q <= done_pulse_d;
        end
    end

`ifdef UART_BITCNT_OVERRUN_EN
    logic overrun_q, overrun_d;

    assign overrun_d = doit && (overrun_q || (state_q == S_DONE && btu));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    phase_t           phase_w;
    logic [CNT_W-1:0] idx_w;

    // Phase is decoded from the registered count so it tracks count with no extra delay.
    always_comb begin
        phase_w = PH_IDLE;
        idx_w   = '0;
        case (state_q)
            S_RUN: begin
                if (count_q == '0) begin
                    phase_w = PH_START;
                end else if (count_q <= CNT_W'(dbits_q)) begin
                    phase_w = PH_DATA;
                    idx_w   = count_q - CNT_W'(1);
                end else if (par_q && (count_q == CNT_W'(dbits_q) + CNT_W'(1))) begin
                    phase_w = PH_PARITY;
                end else begin
                    phase_w = PH_STOP;
                end
            end
            S_DONE:  phase_w = PH_DONE;
            default: phase_w = PH_IDLE;
        endcase
    end

    assign count      = count_q;
    assign bit_idx    = idx_w[3:0];
    assign phase      = phase_w;
    assign done       = (state_q == S_DONE);
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_uart_frame_bit_counter.sv
// Bench for uart_frame_bit_counter: directed frames plus random frames against a frame-level model.
`timescale 1ns/1ps

module tb_uart_frame_bit_counter;

    localparam int MAXD = 8;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          doit = 1'b0;
    logic          btu = 1'b0;
    logic [3:0]    data_bits = 4'd8;
    logic          parity_en = 1'b0;
    logic          stop2 = 1'b0;
    logic [CW-1:0] count;
    logic [3:0]    bit_idx;
    logic [2:0]    phase;
    logic          done;
    logic          done_pulse;
    logic          overrun;

    uart_frame_bit_counter #(.MAX_DATA_BITS(MAXD), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .doit       (doit),
        .btu        (btu),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .stop2      (stop2),
        .count      (count),
        .bit_idx    (bit_idx),
        .phase      (phase),
        .done       (done),
        .done_pulse (done_pulse),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level model: mode 0 = no frame, 1 = counting, 2 = finished.
    int m_mode = 0;
    int m_n    = 0;
    int m_D    = 5;
    int m_L    = 0;
    bit m_par  = 0;
    bit m_pulse = 0;
    bit m_ovr  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_phase();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 5;
        if (m_n == 0) return 1;
        if (m_n <= m_D) return 2;
        if (m_par && m_n == m_D + 1) return 3;
        return 4;
    endfunction

    function automatic int exp_idx();
        if (m_mode == 1 && m_n >= 1 && m_n <= m_D) return m_n - 1;
        return 0;
    endfunction

    task automatic check_all(input string ctx);
        chk({ctx, ".count"},      32'(count),      32'(m_n));
        chk({ctx, ".phase"},      32'(phase),      32'(exp_phase()));
        chk({ctx, ".bit_idx"},    32'(bit_idx),    32'(exp_idx()));
        chk({ctx, ".done"},       32'(done),       32'(m_mode == 2));
        chk({ctx, ".done_pulse"}, 32'(done_pulse), 32'(m_pulse));
        chk({ctx, ".overrun"},    32'(overrun),    32'(m_ovr));
    endtask

    task automatic model_step(input bit d, input bit b);
        int db;
        m_pulse = 0;
        if (!d) begin
            m_mode = 0; m_n = 0; m_ovr = 0;
        end else if (m_mode == 0) begin
            db    = int'(data_bits);
            m_D   = (db < 5) ? 5 : ((db > MAXD) ? MAXD : db);
            m_par = parity_en;
            m_L   = 1 + m_D + int'(parity_en) + (stop2 ? 2 : 1);
            m_mode = 1; m_n = 0;
        end else if (m_mode == 1 && b) begin
            m_n++;
            if (m_n == m_L) begin
                m_mode = 2; m_pulse = 1;
            end
        end else if (m_mode == 2 && b) begin
`ifdef UART_BITCNT_OVERRUN_EN
            m_ovr = 1;
`endif
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_pulse = 0; m_ovr = 0;
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic cyc(input bit d, input bit b, input string ctx);
        doit = d;
        btu  = b;
        @(posedge clk);
        model_step(d, b);
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic set_cfg(input int db, input bit p, input bit s2);
        data_bits = 4'(db);
        parity_en = p;
        stop2     = s2;
    endtask

    task automatic start_frame(input int db, input bit p, input bit s2, input string ctx);
        cyc(0, 0, ctx);
        set_cfg(db, p, s2);
        cyc(1, 1'($urandom_range(0, 1)), ctx);
    endtask

    task automatic ticks(input int n, input string ctx);
        for (int i = 0; i < n; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) cyc(1, 0, ctx);
            cyc(1, 1, ctx);
        end
    endtask

    initial begin
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 0, "idle");

        // 8E1: full frame, then pulse must drop the following cycle.
        start_frame(8, 1, 0, "8E1");
        ticks(10, "8E1");
        chk("8E1.pre_done", 32'(done), 32'd0);
        ticks(1, "8E1");
        chk("8E1.done_lvl", 32'(done), 32'd1);
        chk("8E1.done_pls", 32'(done_pulse), 32'd1);
        chk("8E1.count11", 32'(count), 32'd11);
        cyc(1, 0, "8E1.hold");
        chk("8E1.pls_once", 32'(done_pulse), 32'd0);

        // 7N2 with a btu on the doit rise that must be ignored.
        cyc(0, 0, "7N2");
        set_cfg(7, 0, 1);
        cyc(1, 1, "7N2.rise");
        chk("7N2.ignored", 32'(count), 32'd0);
        ticks(8, "7N2");
        chk("7N2.stop8", 32'(phase), 32'd4);
        ticks(1, "7N2");
        chk("7N2.stop9", 32'(phase), 32'd4);
        ticks(1, "7N2");
        chk("7N2.done10", 32'(done), 32'd1);

        // Clamping of data_bits below and above the legal range.
        start_frame(3, 0, 0, "clamp_lo");
        ticks(7, "clamp_lo");
        chk("clamp_lo.done", 32'(done), 32'd1);
        start_frame(12, 0, 0, "clamp_hi");
        ticks(9, "clamp_hi");
        chk("clamp_hi.stop", 32'(phase), 32'd4);
        ticks(1, "clamp_hi");
        chk("clamp_hi.done", 32'(count), 32'd10);

        // Abort at count 4, then restart from 0.
        start_frame(8, 1, 0, "abort");
        ticks(4, "abort");
        cyc(0, 0, "abort.drop");
        chk("abort.count", 32'(count), 32'd0);
        chk("abort.phase", 32'(phase), 32'd0);
        cyc(1, 0, "abort.restart");
        ticks(11, "abort.restart");

        // Config change mid-frame has no effect.
        start_frame(8, 1, 0, "cfgchg");
        ticks(3, "cfgchg");
        set_cfg(5, 0, 0);
        ticks(8, "cfgchg");
        chk("cfgchg.count", 32'(count), 32'd11);

        // Post-done btus, then async reset mid-frame.
        cyc(1, 1, "postdone");
        cyc(1, 1, "postdone");
        chk("postdone.count", 32'(count), 32'd11);
        chk("postdone.done", 32'(done), 32'd1);
`ifdef UART_BITCNT_OVERRUN_EN
        chk("postdone.ovr", 32'(overrun), 32'd1);
`else
        chk("postdone.ovr", 32'(overrun), 32'd0);
`endif
        start_frame(8, 1, 0, "arst");
        ticks(5, "arst");
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all("arst.async");
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, 0, "arst.after");

        // Random frames with random config, gaps, occasional aborts and post-done ticks.
        for (int f = 0; f < 40; f++) begin
            start_frame($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), "rnd");
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 49) == 0) cyc(0, 1'($urandom_range(0, 1)), "rnd.abort");
                else cyc(1, 1'($urandom_range(0, 2) != 0), "rnd");
                if ($urandom_range(0, 3) == 0) set_cfg($urandom_range(0, 15),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
